// File: rtl/uart_xcvr_if.sv
// uart_xcvr_if: byte streams (tx_data/tx_valid/tx_ready, rx_data/rx_valid/rx_ready, rx_parity_err/rx_frame_err/rx_overrun) and serial pins (tx, rx); slave is the transceiver side
interface uart_xcvr_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] tx_data;
  logic tx_valid, tx_ready, tx, rx;
  logic [DATA_BITS-1:0] rx_data;
  logic rx_valid, rx_ready, rx_parity_err, rx_frame_err, rx_overrun;
  modport master(output tx_data, tx_valid, rx, rx_ready, input tx_ready, tx, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun);
  modport slave(input tx_data, tx_valid, rx, rx_ready, output tx_ready, tx, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun);
endinterface

// File: rtl/uart_xcvr.sv
// uart_xcvr: full-duplex UART transceiver with configurable framing; ports clk, rst (sync active-high), u (uart_xcvr_if.slave: tx stream in, tx pin out, rx pin in, rx stream and error flags out)
module uart_xcvr #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS = 1
) (
  input logic clk,
  input logic rst,
  uart_xcvr_if.slave u
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [3:0] DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] SLAST = 4'(STOP_BITS - 1);
  localparam logic ODD = PARITY_MODE == 2;
  localparam logic PAR_EN = PARITY_MODE != 0;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;
  state_e ts_q, ts_d, rs_q, rs_d;
  logic [CW-1:0] tcnt_q, tcnt_d, rcnt_q, rcnt_d;
  logic [3:0] tbit_q, tbit_d, rbit_q, rbit_d;
  logic [DATA_BITS-1:0] tsh_q, tsh_d, rsh_q, rsh_d, rdat_q, rdat_d;
  logic tpar_q, tpar_d, tx_q, tx_d;
  logic s1_q, s2_q, s3_q;
  logic rperr_q, rperr_d, rferr_q, rferr_d;
  logic rv_q, rv_d, pe_q, pe_d, fe_q, fe_d, ov_q, ov_d;
  logic tend, samp, done, ld;
  always_comb begin
    tend = tcnt_q == LAST;
    ts_d = ts_q;
    tcnt_d = ts_q == IDLE || tend ? '0 : tcnt_q + 1'b1;
    tbit_d = tbit_q;
    tsh_d = tsh_q;
    tpar_d = tpar_q;
    case (ts_q)
      IDLE: if (u.tx_valid) begin
        ts_d = START;
        tsh_d = u.tx_data;
        tpar_d = ^u.tx_data ^ ODD;
      end
      START: if (tend) ts_d = DATA;
      DATA: if (tend) begin
        tsh_d = tsh_q >> 1;
        tbit_d = tbit_q == DLAST ? '0 : tbit_q + 1'b1;
        if (tbit_q == DLAST) ts_d = PAR_EN ? PAR : STOP;
      end
      PAR: if (tend) ts_d = STOP;
      STOP: if (tend) begin
        tbit_d = tbit_q == SLAST ? '0 : tbit_q + 1'b1;
        if (tbit_q == SLAST) ts_d = IDLE;
      end
      default: ts_d = IDLE;
    endcase
    tx_d = ts_d == START ? 1'b0 : ts_d == DATA ? tsh_d[0] : ts_d == PAR ? tpar_d : 1'b1;
  end
  always_comb begin
    samp = rcnt_q == (rs_q == START ? HALF : LAST);
    rs_d = rs_q;
    rcnt_d = rs_q == IDLE ? CW'(1) : samp ? '0 : rcnt_q + 1'b1;
    rbit_d = rbit_q;
    rsh_d = rsh_q;
    rperr_d = rperr_q;
    rferr_d = rferr_q;
    done = 1'b0;
    case (rs_q)
      IDLE: if (s3_q && !s2_q) rs_d = START;
      START: if (samp) begin
        rs_d = s2_q ? IDLE : DATA;
        rperr_d = 1'b0;
        rferr_d = 1'b0;
      end
      DATA: if (samp) begin
        rsh_d = {s2_q, rsh_q[DATA_BITS-1:1]};
        rbit_d = rbit_q == DLAST ? '0 : rbit_q + 1'b1;
        if (rbit_q == DLAST) rs_d = PAR_EN ? PAR : STOP;
      end
      PAR: if (samp) begin
        rperr_d = s2_q != (^rsh_q ^ ODD);
        rs_d = STOP;
      end
      STOP: if (samp) begin
        rferr_d = rferr_q | !s2_q;
        rbit_d = rbit_q == SLAST ? '0 : rbit_q + 1'b1;
        done = rbit_q == SLAST;
        if (rbit_q == SLAST) rs_d = IDLE;
      end
      default: rs_d = IDLE;
    endcase
    ld = done && (!rv_q || u.rx_ready);
    rv_d = ld || (rv_q && !u.rx_ready);
    rdat_d = ld ? rsh_q : rdat_q;
    pe_d = ld ? rperr_q : pe_q;
    fe_d = ld ? rferr_d : fe_q;
    ov_d = done && rv_q && !u.rx_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= IDLE;
      tcnt_q <= '0;
      tbit_q <= '0;
      tsh_q <= '0;
      tpar_q <= 1'b0;
      tx_q <= 1'b1;
      rs_q <= IDLE;
      rcnt_q <= '0;
      rbit_q <= '0;
      rsh_q <= '0;
      rperr_q <= 1'b0;
      rferr_q <= 1'b0;
      {s1_q, s2_q, s3_q} <= '0;
      rdat_q <= '0;
      {rv_q, pe_q, fe_q, ov_q} <= '0;
    end else begin
      ts_q <= ts_d;
      tcnt_q <= tcnt_d;
      tbit_q <= tbit_d;
      tsh_q <= tsh_d;
      tpar_q <= tpar_d;
      tx_q <= tx_d;
      rs_q <= rs_d;
      rcnt_q <= rcnt_d;
      rbit_q <= rbit_d;
      rsh_q <= rsh_d;
      rperr_q <= rperr_d;
      rferr_q <= rferr_d;
      {s1_q, s2_q, s3_q} <= {u.rx, s1_q, s2_q};
      rdat_q <= rdat_d;
      {rv_q, pe_q, fe_q, ov_q} <= {rv_d, pe_d, fe_d, ov_d};
    end
  end
  assign u.tx = tx_q;
  assign u.tx_ready = ts_q == IDLE;
  assign u.rx_data = rdat_q;
  assign u.rx_valid = rv_q;
  assign u.rx_parity_err = pe_q;
  assign u.rx_frame_err = fe_q;
  assign u.rx_overrun = ov_q;
endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: directed checks of uart_xcvr in 8N1 loopback, 7E1 and 8O2 configurations
module tb_uart_xcvr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lb = 1'b0;
  logic [2:0] rxd = 3'b111;
  logic [2:0] rdy = 3'b000;
  logic [2:0] pv = 3'b000;
  int r0, r1, r2, o0;
  int pass_n = 0;
  int tot_n = 0;
  always #5 clk = ~clk;
  uart_xcvr_if #(.DATA_BITS(8)) i0();
  uart_xcvr_if #(.DATA_BITS(7)) i1();
  uart_xcvr_if #(.DATA_BITS(8)) i2();
  uart_xcvr d0(.clk(clk), .rst(rst), .u(i0));
  uart_xcvr #(.DATA_BITS(7), .PARITY_MODE(1)) d1(.clk(clk), .rst(rst), .u(i1));
  uart_xcvr #(.PARITY_MODE(2), .STOP_BITS(2)) d2(.clk(clk), .rst(rst), .u(i2));
  assign i0.rx = lb ? i0.tx : rxd[0];
  assign i1.rx = rxd[1];
  assign i2.rx = rxd[2];
  assign i0.rx_ready = rdy[0];
  assign i1.rx_ready = rdy[1];
  assign i2.rx_ready = rdy[2];
  assign i1.tx_valid = 1'b0;
  assign i1.tx_data = '0;
  assign i2.tx_valid = 1'b0;
  assign i2.tx_data = '0;
  always @(negedge clk) begin
    pv <= {i2.rx_valid, i1.rx_valid, i0.rx_valid};
    if (i0.rx_valid && !pv[0]) r0 <= r0 + 1;
    if (i1.rx_valid && !pv[1]) r1 <= r1 + 1;
    if (i2.rx_valid && !pv[2]) r2 <= r2 + 1;
    if (i0.rx_overrun) o0 <= o0 + 1;
  end
  task automatic drv(input int k, input logic [15:0] b, input int n);
    for (int j = 0; j < n; j++) begin
      rxd[k] = b[j];
      repeat (16) @(negedge clk);
    end
  endtask
  task automatic pop(input int k);
    rdy[k] = 1'b1;
    @(negedge clk);
    rdy[k] = 1'b0;
  endtask
  task automatic tx_send(input logic [7:0] d);
    int n;
    n = 0;
    while (i0.tx_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    tot_n++; if (n >= 400) $display("FAIL tx_ready_wait got %b want 1", i0.tx_ready); else pass_n++;
    i0.tx_data = d;
    i0.tx_valid = 1'b1;
    @(negedge clk);
    i0.tx_valid = 1'b0;
    i0.tx_data = 8'hFF;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    tot_n++; if (i0.tx !== 1'b1) $display("FAIL reset_tx got %b want 1", i0.tx); else pass_n++;
    tot_n++; if (i0.tx_ready !== 1'b1) $display("FAIL reset_tx_ready got %b want 1", i0.tx_ready); else pass_n++;
    tot_n++; if (i0.rx_data !== 8'h00) $display("FAIL reset_rx_data got %h want 00", i0.rx_data); else pass_n++;
    tot_n++; if ({i0.rx_valid, i0.rx_parity_err, i0.rx_frame_err, i0.rx_overrun} !== 4'b0000)
      $display("FAIL reset_rx_flags got %b want 0000", {i0.rx_valid, i0.rx_parity_err, i0.rx_frame_err, i0.rx_overrun}); else pass_n++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_tx_loopback();
    logic [9:0] f;
    logic ok, got, rl;
    f = {1'b1, 8'hA5, 1'b0};
    lb = 1'b1;
    tx_send(8'hA5);
    rl = 1'b0;
    for (int j = 0; j < 10; j++) begin
      ok = 1'b1;
      got = f[j];
      for (int c = 0; c < 16; c++) begin
        if (i0.tx !== f[j]) begin ok = 1'b0; got = i0.tx; end
        if (j == 9 && c == 15) rl = i0.tx_ready;
        @(negedge clk);
      end
      tot_n++; if (!ok) $display("FAIL tx_bit%0d got %b want %b", j, got, f[j]); else pass_n++;
    end
    tot_n++; if (rl !== 1'b0) $display("FAIL tx_ready_last_stop got %b want 0", rl); else pass_n++;
    tot_n++; if (i0.tx_ready !== 1'b1) $display("FAIL tx_ready_after got %b want 1", i0.tx_ready); else pass_n++;
    tot_n++; if (i0.rx_valid !== 1'b1) $display("FAIL lb_rx_valid got %b want 1", i0.rx_valid); else pass_n++;
    tot_n++; if (i0.rx_data !== 8'hA5) $display("FAIL lb_rx_data got %h want a5", i0.rx_data); else pass_n++;
    tot_n++; if ({i0.rx_parity_err, i0.rx_frame_err} !== 2'b00) $display("FAIL lb_rx_err got %b want 00", {i0.rx_parity_err, i0.rx_frame_err}); else pass_n++;
    pop(0);
    tot_n++; if (i0.rx_valid !== 1'b0) $display("FAIL lb_rx_pop got %b want 0", i0.rx_valid); else pass_n++;
  endtask
  task automatic test_back_to_back();
    int n;
    lb = 1'b0;
    tx_send(8'h5A);
    n = 0;
    while (i0.tx_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    tot_n++; if (n != 160) $display("FAIL b2b_frame_len got %0d want 160", n); else pass_n++;
    tx_send(8'hC3);
    tot_n++; if (i0.tx !== 1'b0) $display("FAIL b2b_start got %b want 0", i0.tx); else pass_n++;
    repeat (16) @(negedge clk);
    tot_n++; if (i0.tx !== 1'b1) $display("FAIL b2b_bit0 got %b want 1", i0.tx); else pass_n++;
    repeat (150) @(negedge clk);
    lb = 1'b1;
  endtask
  task automatic test_overrun();
    int o;
    tx_send(8'h11);
    repeat (160) @(negedge clk);
    o = o0;
    tx_send(8'h22);
    repeat (160) @(negedge clk);
    tot_n++; if (i0.rx_valid !== 1'b1) $display("FAIL ovr_valid got %b want 1", i0.rx_valid); else pass_n++;
    tot_n++; if (i0.rx_data !== 8'h11) $display("FAIL ovr_keep_data got %h want 11", i0.rx_data); else pass_n++;
    tot_n++; if (o0 - o != 1) $display("FAIL ovr_pulse_cycles got %0d want 1", o0 - o); else pass_n++;
    pop(0);
    tx_send(8'h11);
    repeat (160) @(negedge clk);
    o = o0;
    tx_send(8'h22);
    repeat (154) @(negedge clk);
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    repeat (4) @(negedge clk);
    tot_n++; if (i0.rx_valid !== 1'b1) $display("FAIL ovr_swap_valid got %b want 1", i0.rx_valid); else pass_n++;
    tot_n++; if (i0.rx_data !== 8'h22) $display("FAIL ovr_swap_data got %h want 22", i0.rx_data); else pass_n++;
    tot_n++; if (o0 - o != 0) $display("FAIL ovr_swap_pulse got %0d want 0", o0 - o); else pass_n++;
    pop(0);
  endtask
  task automatic test_reset_mid();
    int r;
    tx_send(8'h0F);
    repeat (69) @(negedge clk);
    r = r0;
    rst = 1'b1;
    @(negedge clk);
    tot_n++; if (i0.tx !== 1'b1) $display("FAIL rmid_tx got %b want 1", i0.tx); else pass_n++;
    tot_n++; if (i0.tx_ready !== 1'b1) $display("FAIL rmid_tx_ready got %b want 1", i0.tx_ready); else pass_n++;
    rst = 1'b0;
    repeat (200) @(negedge clk);
    tot_n++; if (r0 - r != 0 || i0.rx_valid !== 1'b0) $display("FAIL rmid_no_valid got %0d want 0", r0 - r); else pass_n++;
    tx_send(8'h81);
    repeat (160) @(negedge clk);
    tot_n++; if (i0.rx_valid !== 1'b1) $display("FAIL rmid_next_valid got %b want 1", i0.rx_valid); else pass_n++;
    tot_n++; if (i0.rx_data !== 8'h81) $display("FAIL rmid_next_data got %h want 81", i0.rx_data); else pass_n++;
    pop(0);
  endtask
  task automatic test_glitch();
    int r;
    lb = 1'b0;
    r = r0;
    rxd[0] = 1'b0;
    repeat (3) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (40) @(negedge clk);
    tot_n++; if (r0 - r != 0 || i0.rx_valid !== 1'b0) $display("FAIL glitch_no_valid got %0d want 0", r0 - r); else pass_n++;
    drv(0, 16'({1'b1, 8'h12, 1'b0}), 10);
    tot_n++; if (i0.rx_valid !== 1'b1) $display("FAIL glitch_next_valid got %b want 1", i0.rx_valid); else pass_n++;
    tot_n++; if (i0.rx_data !== 8'h12) $display("FAIL glitch_next_data got %h want 12", i0.rx_data); else pass_n++;
    pop(0);
  endtask
  task automatic test_parity();
    drv(1, 16'({1'b1, 1'b1, 7'h3C, 1'b0}), 10);
    tot_n++; if (i1.rx_valid !== 1'b1) $display("FAIL par_bad_valid got %b want 1", i1.rx_valid); else pass_n++;
    tot_n++; if (i1.rx_data !== 7'h3C) $display("FAIL par_bad_data got %h want 3c", i1.rx_data); else pass_n++;
    tot_n++; if ({i1.rx_parity_err, i1.rx_frame_err} !== 2'b10) $display("FAIL par_bad_err got %b want 10", {i1.rx_parity_err, i1.rx_frame_err}); else pass_n++;
    pop(1);
    drv(1, 16'({1'b1, 1'b0, 7'h3C, 1'b0}), 10);
    tot_n++; if (i1.rx_data !== 7'h3C) $display("FAIL par_good_data got %h want 3c", i1.rx_data); else pass_n++;
    tot_n++; if ({i1.rx_valid, i1.rx_parity_err, i1.rx_frame_err} !== 3'b100) $display("FAIL par_good_flags got %b want 100", {i1.rx_valid, i1.rx_parity_err, i1.rx_frame_err}); else pass_n++;
    pop(1);
  endtask
  task automatic test_framing();
    drv(2, 16'({1'b0, 1'b1, 1'b1, 8'h55, 1'b0}), 12);
    tot_n++; if (i2.rx_valid !== 1'b1) $display("FAIL frm_valid got %b want 1", i2.rx_valid); else pass_n++;
    tot_n++; if (i2.rx_data !== 8'h55) $display("FAIL frm_data got %h want 55", i2.rx_data); else pass_n++;
    tot_n++; if ({i2.rx_parity_err, i2.rx_frame_err} !== 2'b01) $display("FAIL frm_err got %b want 01", {i2.rx_parity_err, i2.rx_frame_err}); else pass_n++;
    rxd[2] = 1'b1;
    repeat (16) @(negedge clk);
    pop(2);
  endtask
  task automatic test_break();
    int r;
    r = r2;
    rxd[2] = 1'b0;
    repeat (320) @(negedge clk);
    tot_n++; if (r2 - r != 1) $display("FAIL brk_valid_count got %0d want 1", r2 - r); else pass_n++;
    tot_n++; if (i2.rx_data !== 8'h00) $display("FAIL brk_data got %h want 00", i2.rx_data); else pass_n++;
    tot_n++; if (i2.rx_frame_err !== 1'b1) $display("FAIL brk_frame_err got %b want 1", i2.rx_frame_err); else pass_n++;
    pop(2);
    r = r2;
    repeat (64) @(negedge clk);
    tot_n++; if (r2 - r != 0 || i2.rx_valid !== 1'b0) $display("FAIL brk_quiet got %0d want 0", r2 - r); else pass_n++;
    rxd[2] = 1'b1;
    repeat (32) @(negedge clk);
    drv(2, 16'({1'b1, 1'b1, 1'b1, 8'h12, 1'b0}), 12);
    tot_n++; if (i2.rx_data !== 8'h12) $display("FAIL brk_next_data got %h want 12", i2.rx_data); else pass_n++;
    tot_n++; if ({i2.rx_valid, i2.rx_parity_err, i2.rx_frame_err} !== 3'b100) $display("FAIL brk_next_flags got %b want 100", {i2.rx_valid, i2.rx_parity_err, i2.rx_frame_err}); else pass_n++;
    pop(2);
  endtask
  initial begin
    i0.tx_valid = 1'b0;
    i0.tx_data = 8'h00;
    test_reset();
    test_tx_loopback();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_glitch();
    test_parity();
    test_framing();
    test_break();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
